// File: rtl/conv_bus_pkg.sv
// Shared types and constants for the convolution unit bus arbiter.
// Request fields are stored at the default bus widths.
package conv_bus_pkg;

    localparam int PKG_ADDR_W = 28;
    localparam int PKG_LEN_W  = 4;
    localparam int PKG_ID_W   = 4;

    localparam int ARB_RR     = 0;
    localparam int ARB_WR_PRI = 1;
    localparam int ARB_RD_PRI = 2;

    typedef enum logic [1:0] {
        IDLE,
        RD_ADDR,
        WR_ADDR,
        WR_DATA
    } arb_state_e;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_LEN_W-1:0]  len;
        logic [PKG_ID_W-1:0]   id;
    } addr_req_t;

endpackage

// File: rtl/conv_outst_cnt.sv
// Saturating up/down counter of outstanding read bursts, with full/empty flags
// and a sticky underflow flag that is only observed by the embedded assertion.
module conv_outst_cnt #(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic underflow_q;

    // A simultaneous increment and decrement cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            underflow_q <= 1'b0;
        end else if (inc && !dec) begin
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (empty) begin
                underflow_q <= 1'b1;
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign full  = (count == CNT_W'(MAX_OUTST));
    assign empty = (count == '0);

    no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !underflow_q);

endmodule

// File: rtl/conv_bus_arb.sv
// Registered, Z-free arbiter putting the conv read and write bridges onto one
// address channel plus a write-data channel, with outstanding-read tracking.
module conv_bus_arb
    import conv_bus_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = PKG_ADDR_W,
    parameter int ID_W        = PKG_ID_W,
    parameter int LEN_W       = PKG_LEN_W,
    parameter int MAX_OUTST   = 4,
    parameter int ARB_MODE    = ARB_RR,
    parameter int WR_AFTER_RD = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd_en,
    input  logic                          wr_en,
    input  logic                          rd_arvalid,
    input  logic [ADDR_W-1:0]             rd_araddr,
    input  logic [LEN_W-1:0]              rd_arlen,
    input  logic [ID_W-1:0]               rd_arid,
    output logic                          rd_arready,
    output logic                          rd_rvalid,
    output logic [DATA_W-1:0]             rd_rdata,
    output logic                          rd_rlast,
    output logic [ID_W-1:0]               rd_rid,
    input  logic                          wr_awvalid,
    input  logic [ADDR_W-1:0]             wr_awaddr,
    input  logic [LEN_W-1:0]              wr_awlen,
    input  logic [ID_W-1:0]               wr_awid,
    output logic                          wr_awready,
    input  logic                          wr_wvalid,
    input  logic [DATA_W-1:0]             wr_wdata,
    input  logic [DATA_W/8-1:0]           wr_wstrb,
    output logic                          wr_wready,
    output logic                          bus_avalid,
    input  logic                          bus_aready,
    output logic                          bus_awrite,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic [LEN_W-1:0]              bus_alen,
    output logic [ID_W-1:0]               bus_aid,
    output logic                          bus_wvalid,
    output logic [DATA_W-1:0]             bus_wdata,
    output logic [DATA_W/8-1:0]           bus_wstrb,
    output logic                          bus_wlast,
    input  logic                          bus_wready,
    input  logic                          bus_rvalid,
    input  logic [DATA_W-1:0]             bus_rdata,
    input  logic                          bus_rlast,
    input  logic [ID_W-1:0]               bus_rid,
    output logic [$clog2(MAX_OUTST+1)-1:0] rd_outst,
    output logic                          busy
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    arb_state_e       state;
    addr_req_t        req_q;
    logic [LEN_W-1:0] beat_cnt;
    logic             prefer_rd;
    logic             rd_elig;
    logic             wr_elig;
    logic             grant_rd;
    logic             grant_wr;
    logic             outst_inc;
    logic             outst_dec;
    logic             outst_full;
    logic             outst_empty;
    logic             in_wdata;
    logic             w_hs;

    conv_outst_cnt #(
        .MAX_OUTST (MAX_OUTST),
        .CNT_W     (CNT_W)
    ) u_outst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (outst_inc),
        .dec   (outst_dec),
        .count (rd_outst),
        .full  (outst_full),
        .empty (outst_empty)
    );

    assign outst_inc = (state == RD_ADDR) && bus_aready;
    assign outst_dec = bus_rvalid && bus_rlast;

    // prefer_rd doubles as the round-robin pointer: set means read goes next.
    always_comb begin
        rd_elig  = rd_en && rd_arvalid && !outst_full;
        wr_elig  = wr_en && wr_awvalid && !((WR_AFTER_RD != 0) && !outst_empty);
        grant_rd = rd_elig;
        if (rd_elig && wr_elig) begin
            case (ARB_MODE)
                ARB_WR_PRI: grant_rd = 1'b0;
                ARB_RD_PRI: grant_rd = 1'b1;
                default:    grant_rd = prefer_rd;
            endcase
        end
        grant_wr = wr_elig && !grant_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_q      <= '0;
            beat_cnt   <= '0;
            prefer_rd  <= 1'b1;
            bus_avalid <= 1'b0;
            bus_awrite <= 1'b0;
            rd_arready <= 1'b0;
            wr_awready <= 1'b0;
        end else begin
            rd_arready <= 1'b0;
            wr_awready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_rd) begin
                        req_q.addr <= PKG_ADDR_W'(rd_araddr);
                        req_q.len  <= PKG_LEN_W'(rd_arlen);
                        req_q.id   <= PKG_ID_W'(rd_arid);
                        bus_avalid <= 1'b1;
                        bus_awrite <= 1'b0;
                        rd_arready <= 1'b1;
                        prefer_rd  <= 1'b0;
                        state      <= RD_ADDR;
                    end else if (grant_wr) begin
                        req_q.addr <= PKG_ADDR_W'(wr_awaddr);
                        req_q.len  <= PKG_LEN_W'(wr_awlen);
                        req_q.id   <= PKG_ID_W'(wr_awid);
                        bus_avalid <= 1'b1;
                        bus_awrite <= 1'b1;
                        wr_awready <= 1'b1;
                        prefer_rd  <= 1'b1;
                        state      <= WR_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (bus_aready) begin
                        bus_avalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                WR_ADDR: begin
                    if (bus_aready) begin
                        bus_avalid <= 1'b0;
                        beat_cnt   <= LEN_W'(req_q.len);
                        state      <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        if (beat_cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - LEN_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write data flows straight through, but is forced to 0 outside the data phase.
    assign in_wdata   = (state == WR_DATA);
    assign bus_wvalid = in_wdata && wr_wvalid;
    assign wr_wready  = in_wdata && bus_wready;
    assign w_hs       = bus_wvalid && bus_wready;
    assign bus_wdata  = in_wdata ? wr_wdata : '0;
    assign bus_wstrb  = in_wdata ? wr_wstrb : '0;
    assign bus_wlast  = in_wdata && (beat_cnt == '0);

    assign bus_addr = ADDR_W'(req_q.addr);
    assign bus_alen = LEN_W'(req_q.len);
    assign bus_aid  = ID_W'(req_q.id);

    assign busy = (state != IDLE) || !outst_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_rvalid <= 1'b0;
            rd_rdata  <= '0;
            rd_rlast  <= 1'b0;
            rd_rid    <= '0;
        end else begin
            rd_rvalid <= bus_rvalid;
            rd_rdata  <= bus_rdata;
            rd_rlast  <= bus_rlast;
            rd_rid    <= bus_rid;
        end
    end

endmodule

// File: tb/tb_conv_bus_arb.sv
// Directed scoreboard bench for conv_bus_arb: one instance with the default
// ordering rule, one with WR_AFTER_RD=0 for the round-robin sequence.
module tb_conv_bus_arb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 28;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 4;
    localparam int CNT_W  = 3;

    logic clk = 1'b0;
    logic rst_n, rr_rst_n;
    logic rd_en, wr_en;
    logic rd_arvalid, wr_awvalid, wr_wvalid;
    logic [ADDR_W-1:0] rd_araddr, wr_awaddr;
    logic [LEN_W-1:0]  rd_arlen, wr_awlen;
    logic [ID_W-1:0]   rd_arid, wr_awid;
    logic [DATA_W-1:0] wr_wdata;
    logic [3:0]        wr_wstrb;
    logic bus_aready, bus_wready, bus_rvalid, bus_rlast;
    logic [DATA_W-1:0] bus_rdata;
    logic [ID_W-1:0]   bus_rid;

    logic rd_arready, rd_rvalid, rd_rlast, wr_awready, wr_wready;
    logic [DATA_W-1:0] rd_rdata, bus_wdata;
    logic [ID_W-1:0]   rd_rid, bus_aid;
    logic bus_avalid, bus_awrite, bus_wvalid, bus_wlast, busy;
    logic [ADDR_W-1:0] bus_addr;
    logic [LEN_W-1:0]  bus_alen;
    logic [3:0]        bus_wstrb;
    logic [CNT_W-1:0]  rd_outst;

    logic rr_rd_arready, rr_rd_rvalid, rr_rd_rlast, rr_wr_awready, rr_wr_wready;
    logic [DATA_W-1:0] rr_rd_rdata, rr_bus_wdata;
    logic [ID_W-1:0]   rr_rd_rid, rr_bus_aid;
    logic rr_bus_avalid, rr_bus_awrite, rr_bus_wvalid, rr_bus_wlast, rr_busy;
    logic [ADDR_W-1:0] rr_bus_addr;
    logic [LEN_W-1:0]  rr_bus_alen;
    logic [3:0]        rr_bus_wstrb;
    logic [CNT_W-1:0]  rr_rd_outst;

    int n_checks = 0;
    int n_fail   = 0;

    logic [36:0] addr_q[$];
    logic [36:0] wdat_q[$];
    logic [36:0] rdat_q[$];
    logic [28:0] rr_q[$];
    logic [36:0] mon_a, mon_w, mon_r;

    always #5 clk = ~clk;

    conv_bus_arb dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en),
        .rd_arvalid(rd_arvalid), .rd_araddr(rd_araddr), .rd_arlen(rd_arlen), .rd_arid(rd_arid),
        .rd_arready(rd_arready), .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .rd_rlast(rd_rlast),
        .rd_rid(rd_rid), .wr_awvalid(wr_awvalid), .wr_awaddr(wr_awaddr), .wr_awlen(wr_awlen),
        .wr_awid(wr_awid), .wr_awready(wr_awready), .wr_wvalid(wr_wvalid), .wr_wdata(wr_wdata),
        .wr_wstrb(wr_wstrb), .wr_wready(wr_wready), .bus_avalid(bus_avalid), .bus_aready(bus_aready),
        .bus_awrite(bus_awrite), .bus_addr(bus_addr), .bus_alen(bus_alen), .bus_aid(bus_aid),
        .bus_wvalid(bus_wvalid), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_wlast(bus_wlast),
        .bus_wready(bus_wready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_rlast(bus_rlast),
        .bus_rid(bus_rid), .rd_outst(rd_outst), .busy(busy)
    );

    conv_bus_arb #(.WR_AFTER_RD(0)) dut_rr (
        .clk(clk), .rst_n(rr_rst_n), .rd_en(rd_en), .wr_en(wr_en),
        .rd_arvalid(rd_arvalid), .rd_araddr(rd_araddr), .rd_arlen(rd_arlen), .rd_arid(rd_arid),
        .rd_arready(rr_rd_arready), .rd_rvalid(rr_rd_rvalid), .rd_rdata(rr_rd_rdata), .rd_rlast(rr_rd_rlast),
        .rd_rid(rr_rd_rid), .wr_awvalid(wr_awvalid), .wr_awaddr(wr_awaddr), .wr_awlen(wr_awlen),
        .wr_awid(wr_awid), .wr_awready(rr_wr_awready), .wr_wvalid(wr_wvalid), .wr_wdata(wr_wdata),
        .wr_wstrb(wr_wstrb), .wr_wready(rr_wr_wready), .bus_avalid(rr_bus_avalid), .bus_aready(bus_aready),
        .bus_awrite(rr_bus_awrite), .bus_addr(rr_bus_addr), .bus_alen(rr_bus_alen), .bus_aid(rr_bus_aid),
        .bus_wvalid(rr_bus_wvalid), .bus_wdata(rr_bus_wdata), .bus_wstrb(rr_bus_wstrb), .bus_wlast(rr_bus_wlast),
        .bus_wready(bus_wready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_rlast(bus_rlast),
        .bus_rid(bus_rid), .rd_outst(rr_rd_outst), .busy(rr_busy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one read-return beat for a cycle and records what the client must see.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic last, input logic [3:0] id);
        bus_rvalid = v;
        bus_rdata  = d;
        bus_rlast  = last;
        bus_rid    = id;
        if (v) rdat_q.push_back({d, last, id});
        nextCycle();
        bus_rvalid = 1'b0;
        bus_rlast  = 1'b0;
    endtask

    task automatic pushAddr(input logic wr, input logic [27:0] a, input logic [3:0] l, input logic [3:0] id);
        addr_q.push_back({wr, a, l, id});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_avalid && bus_aready) begin
                checkOutput("addr_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) begin
                    mon_a = addr_q.pop_front();
                    checkOutput("addr_txn", {bus_awrite, bus_addr, bus_alen, bus_aid}, mon_a);
                end
            end
            if (bus_wvalid && bus_wready) begin
                checkOutput("wbeat_expected", wdat_q.size() != 0, 1);
                if (wdat_q.size() != 0) begin
                    mon_w = wdat_q.pop_front();
                    checkOutput("wbeat", {bus_wdata, bus_wstrb, bus_wlast}, mon_w);
                end
            end
            if (rd_rvalid) begin
                checkOutput("rbeat_expected", rdat_q.size() != 0, 1);
                if (rdat_q.size() != 0) begin
                    mon_r = rdat_q.pop_front();
                    checkOutput("rbeat", {rd_rdata, rd_rlast, rd_rid}, mon_r);
                end
            end
        end
    end

    initial begin
        int beat, cyc, grants;
        rst_n = 1'b0; rr_rst_n = 1'b0;
        rd_en = 1'b0; wr_en = 1'b0;
        rd_arvalid = 1'b0; rd_araddr = '0; rd_arlen = '0; rd_arid = '0;
        wr_awvalid = 1'b0; wr_awaddr = '0; wr_awlen = '0; wr_awid = '0;
        wr_wvalid = 1'b0; wr_wdata = '0; wr_wstrb = 4'hF;
        bus_aready = 1'b1; bus_wready = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD; bus_rlast = 1'b1; bus_rid = 4'h3;

        // Reset state, with read-return traffic present on the bus
        repeat (2) nextCycle();
        checkOutput("rst_avalid", bus_avalid, 0);
        checkOutput("rst_arready", rd_arready, 0);
        checkOutput("rst_awready", wr_awready, 0);
        checkOutput("rst_rvalid", rd_rvalid, 0);
        checkOutput("rst_outst", rd_outst, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_wvalid", bus_wvalid, 0);
        bus_rvalid = 1'b0; bus_rlast = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // Single read, len 3
        rd_en = 1'b1; wr_en = 1'b1;
        pushAddr(1'b0, 28'h0000100, 4'd3, 4'd2);
        rd_arvalid = 1'b1; rd_araddr = 28'h0000100; rd_arlen = 4'd3; rd_arid = 4'd2;
        checkOutput("rd_avalid_n", bus_avalid, 0);
        nextCycle();
        checkOutput("rd_avalid_n1", bus_avalid, 1);
        checkOutput("rd_arready_pulse", rd_arready, 1);
        checkOutput("rd_awrite", bus_awrite, 0);
        rd_arvalid = 1'b0;
        nextCycle();
        checkOutput("rd_avalid_once", bus_avalid, 0);
        checkOutput("rd_arready_drop", rd_arready, 0);
        checkOutput("rd_outst_1", rd_outst, 1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'hA000_0000 + k, k == 3, 4'd2);
            checkOutput("rd_outst_beats", rd_outst, (k == 3) ? 0 : 1);
        end
        nextCycle();
        checkOutput("rd_busy_done", busy, 0);

        // Write burst len 3, bus_wready toggling
        pushAddr(1'b1, 28'h0000200, 4'd3, 4'd5);
        for (int k = 0; k < 4; k++) wdat_q.push_back({32'hB000_0000 + k, 4'hF, k == 3});
        wr_awvalid = 1'b1; wr_awaddr = 28'h0000200; wr_awlen = 4'd3; wr_awid = 4'd5;
        nextCycle();
        checkOutput("wr_awready_pulse", wr_awready, 1);
        checkOutput("wr_avalid", bus_avalid, 1);
        checkOutput("wr_awrite", bus_awrite, 1);
        wr_awvalid = 1'b0;
        nextCycle();
        checkOutput("wr_avalid_once", bus_avalid, 0);
        beat = 0; cyc = 0;
        wr_wvalid = 1'b1;
        while (beat < 4 && cyc < 20) begin
            bus_wready = (cyc % 2 == 0);
            wr_wdata   = 32'hB000_0000 + beat;
            #1;
            checkOutput("wr_wvalid_pass", bus_wvalid, 1);
            checkOutput("wr_wlast", bus_wlast, beat == 3);
            checkOutput("wr_wready_pass", wr_wready, bus_wready);
            if (bus_wready) beat++;
            cyc++;
            nextCycle();
        end
        checkOutput("wr_beats", beat, 4);
        bus_wready = 1'b1;
        #1;
        checkOutput("wr_no_extra_wvalid", bus_wvalid, 0);
        checkOutput("wr_no_extra_wready", wr_wready, 0);
        checkOutput("wr_idle", busy, 0);
        wr_wvalid = 1'b0;

        // Write held back while a read is outstanding
        pushAddr(1'b0, 28'h0000300, 4'd0, 4'd1);
        rd_arvalid = 1'b1; rd_araddr = 28'h0000300; rd_arlen = 4'd0; rd_arid = 4'd1;
        nextCycle();
        rd_arvalid = 1'b0;
        nextCycle();
        checkOutput("ord_outst", rd_outst, 1);
        pushAddr(1'b1, 28'h0000400, 4'd0, 4'd3);
        wr_awvalid = 1'b1; wr_awaddr = 28'h0000400; wr_awlen = 4'd0; wr_awid = 4'd3;
        repeat (4) begin
            nextCycle();
            checkOutput("ord_wr_blocked", wr_awready, 0);
            checkOutput("ord_no_avalid", bus_avalid, 0);
        end
        applyStimulus(1'b1, 32'h0000_00C0, 1'b1, 4'd1);
        checkOutput("ord_after_rlast", wr_awready, 0);
        checkOutput("ord_outst_0", rd_outst, 0);
        nextCycle();
        checkOutput("ord_wr_granted", wr_awready, 1);
        checkOutput("ord_wr_awrite", bus_awrite, 1);
        wr_awvalid = 1'b0;
        wdat_q.push_back({32'h0000_00D0, 4'hF, 1'b1});
        wr_wvalid = 1'b1; wr_wdata = 32'h0000_00D0; bus_wready = 1'b1;
        nextCycle();
        checkOutput("ord_wlast", bus_wlast, 1);
        nextCycle();
        checkOutput("ord_idle", busy, 0);
        wr_wvalid = 1'b0;

        // Outstanding limit of 4
        for (int k = 0; k < 5; k++) pushAddr(1'b0, 28'h0000500, 4'd0, 4'd4);
        rd_arvalid = 1'b1; rd_araddr = 28'h0000500; rd_arlen = 4'd0; rd_arid = 4'd4;
        grants = 0;
        repeat (16) begin
            nextCycle();
            if (rd_arready) grants++;
        end
        checkOutput("lim_grants", grants, 4);
        checkOutput("lim_outst_full", rd_outst, 4);
        checkOutput("lim_busy", busy, 1);
        applyStimulus(1'b1, 32'h0000_00E0, 1'b1, 4'd4);
        grants = 0;
        repeat (12) begin
            if (rd_arready) grants++;
            nextCycle();
        end
        checkOutput("lim_one_more", grants, 1);
        checkOutput("lim_outst_refull", rd_outst, 4);
        rd_arvalid = 1'b0;
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'h0000_00F0 + k, 1'b1, 4'd4);
        checkOutput("lim_drained", rd_outst, 0);

        // Reset during the second write beat
        pushAddr(1'b1, 28'h0000600, 4'd3, 4'd6);
        wdat_q.push_back({32'h0000_0060, 4'hF, 1'b0});
        wr_awvalid = 1'b1; wr_awaddr = 28'h0000600; wr_awlen = 4'd3; wr_awid = 4'd6;
        nextCycle();
        wr_awvalid = 1'b0;
        nextCycle();
        wr_wvalid = 1'b1; wr_wdata = 32'h0000_0060; bus_wready = 1'b1;
        #1;
        checkOutput("mid_beat0_wlast", bus_wlast, 0);
        nextCycle();
        wr_wdata = 32'h0000_0061;
        checkOutput("mid_beat1_wvalid", bus_wvalid, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_wvalid", bus_wvalid, 0);
        checkOutput("mid_rst_wready", wr_wready, 0);
        checkOutput("mid_rst_wlast", bus_wlast, 0);
        checkOutput("mid_rst_wdata", bus_wdata, 0);
        checkOutput("mid_rst_addr", bus_addr, 0);
        checkOutput("mid_rst_awrite", bus_awrite, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_outst", rd_outst, 0);
        nextCycle();
        rst_n = 1'b1;
        wr_wvalid = 1'b0;
        pushAddr(1'b0, 28'h0000700, 4'd1, 4'd7);
        rd_arvalid = 1'b1; rd_araddr = 28'h0000700; rd_arlen = 4'd1; rd_arid = 4'd7;
        nextCycle();
        checkOutput("post_rst_avalid", bus_avalid, 1);
        checkOutput("post_rst_addr", bus_addr, 28'h0000700);
        rd_arvalid = 1'b0;
        nextCycle();
        checkOutput("post_rst_outst", rd_outst, 1);
        applyStimulus(1'b1, 32'h0000_0070, 1'b0, 4'd7);
        applyStimulus(1'b1, 32'h0000_0071, 1'b1, 4'd7);
        checkOutput("post_rst_drained", rd_outst, 0);
        repeat (3) nextCycle();

        // Round-robin with continuous requests on the WR_AFTER_RD=0 instance
        rst_n = 1'b0;
        rr_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rr_q.push_back({1'b0, 28'h0000800});
            rr_q.push_back({1'b1, 28'h0000900});
        end
        rd_arvalid = 1'b1; rd_araddr = 28'h0000800; rd_arlen = 4'd0; rd_arid = 4'd8;
        wr_awvalid = 1'b1; wr_awaddr = 28'h0000900; wr_awlen = 4'd0; wr_awid = 4'd9;
        wr_wvalid = 1'b1; bus_wready = 1'b1;
        cyc = 0;
        while (rr_q.size() != 0 && cyc < 40) begin
            if (rr_bus_avalid && bus_aready) begin
                checkOutput("rr_grant_order", {rr_bus_awrite, rr_bus_addr}, rr_q.pop_front());
            end
            nextCycle();
            cyc++;
        end
        checkOutput("rr_all_grants", rr_q.size(), 0);
        checkOutput("rr_outst", rr_rd_outst, 3);
        rd_arvalid = 1'b0; wr_awvalid = 1'b0; wr_wvalid = 1'b0;
        nextCycle();

        checkOutput("sb_addr_drained", addr_q.size(), 0);
        checkOutput("sb_wdat_drained", wdat_q.size(), 0);
        checkOutput("sb_rdat_drained", rdat_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_bus_arb.md
Name: conv_bus_arb

Overview:
- Shared-bus port for the convolution unit; replaces the tri-state link_read/link_write muxing with a registered, Z-free arbiter.
- Arbitrates one read requester (conv read bridge) and one write requester (conv write bridge) onto a single address channel plus a write-data channel.
- Tracks outstanding read bursts, generates wlast, and supports selectable arbitration and ordering modes.

Parameters:
- DATA_W, 32, data bus width; wstrb width is DATA_W/8.
- ADDR_W, 28, address width.
- ID_W, 4, transaction id width.
- LEN_W, 4, burst length field width; beats = len+1.
- MAX_OUTST, 4, maximum outstanding read bursts (>=1).
- ARB_MODE, 0, arbitration mode: 0 round-robin, 1 write priority, 2 read priority.
- WR_AFTER_RD, 1, when 1 no write grant while any read is outstanding (read-after-write/write-after-read safety).

Ports:
- clk input 1 system clock
- rst_n input 1 asynchronous active-low reset
- rd_en input 1 read client enabled (was link_read)
- wr_en input 1 write client enabled (was link_write)
- rd_arvalid input 1 read request valid
- rd_araddr input ADDR_W read address
- rd_arlen input LEN_W read burst length
- rd_arid input ID_W read id
- rd_arready output 1 read request accepted
- rd_rvalid output 1 read data valid to client
- rd_rdata output DATA_W read data
- rd_rlast output 1 last read beat
- rd_rid output ID_W read data id
- wr_awvalid input 1 write request valid
- wr_awaddr input ADDR_W write address
- wr_awlen input LEN_W write burst length
- wr_awid input ID_W write id
- wr_awready output 1 write request accepted
- wr_wvalid input 1 write data valid
- wr_wdata input DATA_W write data
- wr_wstrb input DATA_W/8 byte strobes
- wr_wready output 1 write data accepted
- bus_avalid output 1 address valid
- bus_aready input 1 address accepted
- bus_awrite output 1 1 = write, 0 = read
- bus_addr output ADDR_W address
- bus_alen output LEN_W burst length
- bus_aid output ID_W transaction id
- bus_wvalid output 1 write data valid
- bus_wdata output DATA_W write data
- bus_wstrb output DATA_W/8 byte strobes
- bus_wlast output 1 last write beat
- bus_wready input 1 write data accepted
- bus_rvalid input 1 read data valid
- bus_rdata input DATA_W read data
- bus_rlast input 1 last read beat
- bus_rid input ID_W read data id
- rd_outst output $clog2(MAX_OUTST+1) outstanding read bursts
- busy output 1 FSM not IDLE or rd_outst != 0

Behaviour:
- Reset: all outputs 0; FSM to IDLE; rd_outst=0; round-robin pointer favours read. No output is ever Z.
- FSM states and transitions:
  - IDLE: evaluate requests. Read is eligible if rd_en & rd_arvalid & rd_outst<MAX_OUTST. Write is eligible if wr_en & wr_awvalid & !(WR_AFTER_RD & rd_outst!=0).
  - IDLE to RD_ADDR: on read grant. Capture addr/len/id into the address register; pulse rd_arready for one cycle (the client request is consumed here).
  - IDLE to WR_ADDR: on write grant. Capture the request; pulse wr_awready for one cycle.
  - RD_ADDR: bus_avalid=1, bus_awrite=0, registered fields held stable. On bus_aready: rd_outst++, go to IDLE.
  - WR_ADDR: bus_avalid=1, bus_awrite=1. On bus_aready: load beat counter with len, go to WR_DATA.
  - WR_DATA: bus_wvalid=wr_wvalid, wr_wready=bus_wready, wdata/wstrb passed through combinationally. Counter decrements on each handshake. bus_wlast=1 while counter==0. A handshake with counter==0 returns to IDLE.
- Latency: request valid in cycle N gives bus_avalid in cycle N+1 at earliest. A full read grant cycle is IDLE, RD_ADDR, back to IDLE: minimum 2 cycles per address.
- Arbitration when both requesters are eligible in the same cycle:
  - ARB_MODE 0: grant the side not granted last; the pointer updates on each grant.
  - ARB_MODE 1: write wins.
  - ARB_MODE 2: read wins.
- Read return path: registered one stage, bus_r* to rd_r*. It is always accepted (no rready), independent of FSM state, and not gated by rd_en.
- rd_outst:
  - +1 on read address handshake; -1 on bus_rvalid & bus_rlast.
  - Both in the same cycle: unchanged.
  - Decrement at 0: ignored, and the sticky internal error flag is set (verification only).
  - At MAX_OUTST: no new read grant; the write side may still be granted if WR_AFTER_RD=0.
- Enable deasserted mid-transaction: the current burst completes; only new grants are blocked.
- Asynchronous reset mid-burst: immediate return to reset state; a partial burst is abandoned.

Decomposition:
- Package conv_bus_pkg holds:
  - arb_state_e (IDLE, RD_ADDR, WR_ADDR, WR_DATA)
  - ARB_RR / ARB_WR_PRI / ARB_RD_PRI constants
  - struct addr_req_t {addr, len, id}
- One natural sub-module: conv_outst_cnt, the saturating up/down outstanding counter with full/empty flags.

Test Plan:
- Single read: rd_arvalid, addr 0x0000100, len 3, id 2; bus_aready tied 1 -> bus_avalid for exactly 1 cycle at N+1; rd_outst goes to 1; after 4 r-beats with rlast on beat 4, rd_outst returns to 0.
- Write burst: len 3, wr_wvalid always 1, bus_wready toggles 1,0,1,0 -> exactly 4 beats transferred; bus_wlast only on the 4th; FSM back to IDLE.
- Round-robin: both clients request continuously, ARB_MODE 0, WR_AFTER_RD=0 -> grants alternate R,W,R,W starting with read.
- Outstanding limit: MAX_OUTST=4, no rlast returned -> 4 read grants, then rd_arready stays 0; one rlast -> exactly one more grant.
- Ordering: WR_AFTER_RD=1, read outstanding plus write request -> no write grant until the rlast cycle; write granted the following cycle.
- Reset mid-burst: rst_n low during WR_DATA beat 2 -> all outputs 0 immediately; rd_outst=0; next request is served normally.
